// File: rtl/pipe_pkg.sv
// Shared constants for the IF/E boundary: bubble word, opcode values, hold-FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pipe_pkg;

  // sll $0,$0,0 -- architecturally a no-op, used as the bubble word
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;

  // RUN: free-running. HOLD: stalled, skid empty. HOLD_SKID: skid holds a word.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HOLD      = 2'd1,
    HOLD_SKID = 2'd2
  } hold_state_t;

endpackage

// File: rtl/inst_skid_buf.sv
// One-entry store for {instruction, PC+4} caught while the E register is held.
// Latency: written on the clock edge, read combinationally from the store.
// Backpressure: none of its own; the parent decides when to load or clear.
//   core_clk/arst_n : clock, async active-low reset
//   load/clear      : capture inst_dat/pc_dat, or drop the entry (clear wins)
//   inst_q/pc_q     : stored word; full marks the entry occupied
module inst_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            core_clk,
  input  logic            arst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] inst_dat,
  input  logic [XLEN-1:0] pc_dat,
  output logic [XLEN-1:0] inst_q,
  output logic [XLEN-1:0] pc_q,
  output logic            full
);

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      full   <= 1'b0;
      inst_q <= '0;
      pc_q   <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full   <= 1'b1;
      inst_q <= inst_dat;
      pc_q   <= pc_dat;
    end
  end

endmodule

// File: rtl/if_ex_pipe_reg.sv
// IF->E pipeline register with stall hold, flush squash and a 1-entry skid for the in-flight fetch.
// Latency: 1 cycle Inst_I->Inst_E when not stalled; a skid-held word leaves on the release edge.
// Backpressure: Stall holds E; one word arriving per stall episode is skidded, a second sets Overflow.
//   Clk/Reset: clock, async active-low reset.  Stall/Flush: hazard controls (Flush wins).
//   InstValid_I/Inst_I/PCplus4_I: fetch word.  Inst_E/PCplus4_E/Valid_E: E register.
//   Rs_E..Jtarget_E: fields decoded from the E register only.  SkidFull/Overflow: status.
module if_ex_pipe_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(pipe_pkg::NOP_INST)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            InstValid_I,
  input  logic [XLEN-1:0] Inst_I,
  input  logic [XLEN-1:0] PCplus4_I,
  output logic [XLEN-1:0] Inst_E,
  output logic [XLEN-1:0] PCplus4_E,
  output logic            Valid_E,
  output logic [4:0]      Rs_E,
  output logic [4:0]      Rt_E,
  output logic [4:0]      Rd_E,
  output logic [4:0]      Shamt_E,
  output logic [XLEN-1:0] Imm_E,
  output logic [XLEN-1:0] Jtarget_E,
  output logic            SkidFull,
  output logic            Overflow
);
  import pipe_pkg::*;

  // What the E register does on the next edge
  typedef enum logic [2:0] {
    E_KEEP,    // hold current contents
    E_FETCH,   // take Inst_I/PCplus4_I
    E_BUBBLE,  // nothing fetched: NOP, PC+4 keeps its value
    E_SKID,    // take the skidded word
    E_SQUASH   // flush: NOP, PC+4 cleared
  } e_op_t;

  hold_state_t     state, state_nxt;
  e_op_t           e_op;
  logic            skid_load, skid_clear, ovf_set;
  logic [XLEN-1:0] skid_inst, skid_pc;
  logic [5:0]      opcode;

  inst_skid_buf #(.XLEN(XLEN)) u_skid (
    .core_clk (Clk),
    .arst_n   (Reset),
    .load     (skid_load),
    .clear    (skid_clear),
    .inst_dat (Inst_I),
    .pc_dat   (PCplus4_I),
    .inst_q   (skid_inst),
    .pc_q     (skid_pc),
    .full     (SkidFull)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    e_op       = E_KEEP;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    ovf_set    = 1'b0;
    if (Flush) begin
      // wrong-path: whatever is fetched or skidded is discarded
      e_op       = E_SQUASH;
      skid_clear = 1'b1;
      state_nxt  = RUN;
    end else if (Stall) begin
      if (state == HOLD_SKID) begin
        ovf_set = InstValid_I;
      end else if (InstValid_I) begin
        skid_load = 1'b1;
        state_nxt = HOLD_SKID;
      end else begin
        state_nxt = HOLD;
      end
    end else if (state == HOLD_SKID) begin
      // release: the skidded word is older than anything on Inst_I
      e_op = E_SKID;
      if (InstValid_I) begin
        skid_load = 1'b1;
      end else begin
        skid_clear = 1'b1;
        state_nxt  = RUN;
      end
    end else begin
      e_op      = InstValid_I ? E_FETCH : E_BUBBLE;
      state_nxt = RUN;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Inst_E    <= NOP_INST;
      PCplus4_E <= '0;
      Valid_E   <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      if (ovf_set) Overflow <= 1'b1;
      case (e_op)
        E_FETCH: begin
          Inst_E    <= Inst_I;
          PCplus4_E <= PCplus4_I;
          Valid_E   <= 1'b1;
        end
        E_BUBBLE: begin
          Inst_E  <= NOP_INST;
          Valid_E <= 1'b0;
        end
        E_SKID: begin
          Inst_E    <= skid_inst;
          PCplus4_E <= skid_pc;
          Valid_E   <= 1'b1;
        end
        E_SQUASH: begin
          Inst_E    <= NOP_INST;
          PCplus4_E <= '0;
          Valid_E   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign opcode  = Inst_E[31:26];
  assign Rs_E    = Inst_E[25:21];
  assign Rt_E    = Inst_E[20:16];
  assign Rd_E    = Inst_E[15:11];
  assign Shamt_E = Inst_E[10:6];

  always_comb begin
    Imm_E = {{(XLEN-16){Inst_E[15]}}, Inst_E[15:0]};
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
      Imm_E = {{(XLEN-16){1'b0}}, Inst_E[15:0]};
    else if (opcode == OP_LUI)
      Imm_E = XLEN'({Inst_E[15:0], 16'h0000});
  end

  // pseudo-direct jump: region bits come from PC+4 of the jump itself
  assign Jtarget_E = XLEN'({PCplus4_E[XLEN-1 -: 4], Inst_E[25:0], 2'b00});

endmodule

// File: doc/if_ex_pipe_reg.md
Name: if_ex_pipe_reg

Overview:
- IF→E boundary register of the 3-stage pipeline; consumes Inst_I / PCplus4_I from the fetch stage and presents a registered instruction, PC+4 and pre-decoded fields to the execute stage.
- Owns stall holding, wrong-path squash on taken branch/jump, and a 1-entry skid buffer that catches the word already in flight out of the synchronous instruction memory when a stall begins.

Parameters:
- XLEN, 32, datapath width of instruction and PC+4.
- NOP_INST, 32'h0000_0000, bubble inserted on reset/flush (sll $0,$0,0).

Ports:
- Clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low; asserted low clears all state immediately.
- Stall  in  1  hazard unit: hold the E-stage register this cycle.
- Flush  in  1  taken Branch_E/Jump_E/JReg redirect; squash everything younger than E.
- InstValid_I  in  1  Inst_I/PCplus4_I carry a real fetched word this cycle.
- Inst_I  in  XLEN  fetched instruction.
- PCplus4_I  in  XLEN  PC+4 of Inst_I.
- Inst_E  out  XLEN  registered instruction.
- PCplus4_E  out  XLEN  registered PC+4.
- Valid_E  out  1  Inst_E is a real instruction, not a bubble.
- Rs_E, Rt_E, Rd_E  out  5 each  Inst_E[25:21], [20:16], [15:11].
- Shamt_E  out  5  Inst_E[10:6].
- Imm_E  out  XLEN  extended Inst_E[15:0].
- Jtarget_E  out  XLEN  {PCplus4_E[31:28], Inst_E[25:0], 2'b00}.
- SkidFull  out  1  skid entry occupied.
- Overflow  out  1  sticky error: word arrived with nowhere to go.

Behaviour:
- Reset low (async): Inst_E=NOP_INST, PCplus4_E=0, Valid_E=0, skid empty, Overflow=0, state RUN. All decoded outputs are 0 as a consequence.
- States:
  - RUN: skid empty, not stalled.
  - HOLD: stalled, skid empty.
  - HOLD_SKID: stalled, skid full.
- Priority per edge: Flush > Stall > normal advance.
- Flush=1:
  - E register ← NOP_INST, Valid_E←0, PCplus4_E←0.
  - Skid cleared; state→RUN.
  - Inst_I is dropped even if InstValid_I=1 (wrong path).
  - Stall is ignored that cycle.
- RUN, Stall=0: E register ← Inst_I/PCplus4_I, Valid_E←InstValid_I. If InstValid_I=0, load NOP_INST and PCplus4_E holds its value.
- RUN, Stall=1: E register holds.
  - InstValid_I=1 → skid captures the word, state→HOLD_SKID.
  - Otherwise state→HOLD.
- HOLD, Stall=1: as RUN with Stall=1.
- HOLD_SKID, Stall=1: E holds, skid holds. InstValid_I=1 → Overflow←1 (sticky until reset) and the word is dropped. Fetch contract: at most one valid word per stall episode.
- HOLD or HOLD_SKID, Stall=0 (release):
  - Skid full: E ← skid, Valid_E←1. If InstValid_I=1 the new word enters skid and the state stays HOLD_SKID (one extra cycle draining); otherwise skid clears and state→RUN.
  - Skid empty: behave as RUN with Stall=0.
- Latency: 1 cycle Inst_I→Inst_E when not stalled. Stall release with a full skid adds no bubble.
- Ordering: instructions leave in exactly fetch order. No duplication and no loss except by Flush or Overflow.
- Imm_E extension:
  - Zero-extend for opcodes ANDI 0x0C, ORI 0x0D, XORI 0x0E.
  - LUI 0x0F gives {Inst_E[15:0], 16'h0}.
  - Sign-extend for all others.
- Decoded fields are combinational from the E register only and never look through to Inst_I.

Decomposition:
- Shared package pipe_pkg: NOP_INST, opcode localparams (OP_ANDI/ORI/XORI/LUI/J/JAL), 2-bit state encodings RUN/HOLD/HOLD_SKID.
- Sub-module inst_skid_buf: 1-entry {Inst, PCplus4} store with load/clear/full. Contains no decode.

Test Plan:
- Reset mid-stream: with Valid_E=1 and skid full, drive Reset low without a clock edge → Inst_E=0, Valid_E=0, SkidFull=0 immediately.
- Streaming, no stall: InstValid_I=1 with Inst_I=32'h2008_0005 (addi $8,$0,5), PCplus4_I=4 → next edge Inst_E=32'h2008_0005, PCplus4_E=4, Rt_E=8, Imm_E=5. Then 32'h3108_FFFF (andi) → Imm_E=32'h0000_FFFF.
- Stall with in-flight word: E holds word A; Stall=1 for 3 cycles while B arrives on the first cycle only → Inst_E stays A, SkidFull=1. On release Inst_E=B in 1 cycle, then C from Inst_I the next cycle with no bubble.
- Flush priority: Flush=1, Stall=1, skid full, InstValid_I=1 → next edge Inst_E=0, Valid_E=0, SkidFull=0. The following valid word loads normally.
- Overflow: in HOLD_SKID present a second valid word → Overflow=1 and it stays 1 after release. Inst_E sequence contains only A, then B.
- Sign/jump decode: Inst_E=32'h2108_FFFC → Imm_E=32'hFFFF_FFFC. Inst_E=32'h0810_0004 with PCplus4_E=32'h0000_1004 → Jtarget_E=32'h0040_0010.
